// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings and widths for the arbitrated ALU.
// Imported by alu_arbiter and alu_arb_grant.
package alu_arbiter_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_B    = 4'd10
    } alu_op_e;

    typedef enum logic [0:0] {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-port grant picker: round-robin on ties, or fixed
// priority to port 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_grant
    import alu_arbiter_pkg::*;
(
    input  logic       elig0,
    input  logic       elig1,
    input  port_e      last_grant,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // One-hot grant; ties go away from the last winner.
    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            elig0 & elig1: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                gnt = 2'b01;
`else
                gnt = (last_grant == PORT1) ? 2'b01 : 2'b10;
`endif
            end
            elig0 & ~elig1: gnt = 2'b01;
            ~elig0 & elig1: gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters
// with registered responses. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero
);

    logic             elig0;
    logic             elig1;
    logic [1:0]       gnt;
    port_e            last_grant;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    // A port with a stalled response cannot take a new result.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready) & ~rst;
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready) & ~rst;

    alu_arb_grant u_grant (
        .elig0      (elig0),
        .elig1      (elig1),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Port 0 feeds the ALU unless port 1 holds the grant.
    assign alu_a  = gnt[1] ? req1_a  : req0_a;
    assign alu_b  = gnt[1] ? req1_b  : req0_b;
    assign alu_op = gnt[1] ? req1_op : req0_op;
    assign shamt  = alu_b[4:0];

    // Shared ALU; unknown op codes produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLL:  alu_res = alu_a << shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                 $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_SRL:  alu_res = alu_a >> shamt;
            ALU_SRA:  alu_res = $signed(alu_a) >>> shamt;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_B:    alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    // Response registers: load on grant, drain on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_zero  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_zero  <= 1'b0;
            last_grant <= PORT1;
        end else begin
            if (gnt[0]) begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= alu_res;
                rsp0_zero  <= alu_zero;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (gnt[1]) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= alu_res;
                rsp1_zero  <= alu_zero;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            if (|gnt) begin
                last_grant <= gnt[1] ? PORT1 : PORT0;
            end
        end
    end

endmodule
